// File: rtl/an_sec_search_decoder.sv
// -----------------------------------------------------------------------------
// an_sec_search_decoder
// Sequential single-error-correcting decoder for AN arithmetic codes. A codeword
// is reduced modulo A and the nonzero residue is matched against +/-2^i, one bit
// position per cycle. The first matching position determines the correction.
//
// Parameters
//   A   odd code constant (>= 3)
//   RW  residue width (>= clog2(A))
//   NW  codeword width; error search covers positions 0..NW-1
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   codeword handshake (in_ready high only when idle)
//   in_cw            received codeword, unsigned
//   out_valid/ready  result handshake
//   out_cw           corrected codeword
//   out_awe          signed arithmetic weight error removed (0 if none)
//   out_pos          bit position of the removed error (0 if none)
//   out_status       0 CLEAN, 1 CORRECTED, 2 UNCORRECTABLE
// -----------------------------------------------------------------------------
module an_sec_search_decoder #(
   parameter int unsigned A  = 83,
   parameter int unsigned RW = 7,
   parameter int unsigned NW = 41
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NW-1:0]         in_cw,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NW-1:0]         out_cw,
   output logic [NW:0]           out_awe,
   output logic [$clog2(NW)-1:0] out_pos,
   output logic [1:0]            out_status
);

   localparam int unsigned PW = $clog2(NW);

   localparam logic [RW:0]   A_W    = (RW+1)'(A);
   localparam logic [RW+1:0] A_W2   = (RW+2)'(A);
   localparam logic [PW-1:0] I_LAST = PW'(NW-1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_SEARCH,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      ST_CLEAN  = 2'd0,
      ST_CORR   = 2'd1,
      ST_UNCORR = 2'd2
   } status_t;

   state_t          state_q, state_d;
   logic [NW-1:0]   cw_q, cw_d;
   logic [RW-1:0]   r_q, r_d;
   logic [PW-1:0]   i_q, i_d;
   logic [RW:0]     p_q, p_d;      // 2^i mod A, always < A
   logic [NW-1:0]   ocw_q, ocw_d;
   logic [NW:0]     oawe_q, oawe_d;
   logic [PW-1:0]   opos_q, opos_d;
   status_t         ost_q, ost_d;
   logic            ovalid_q, ovalid_d;

   logic [RW-1:0]   residue;
   logic            hit_pos, hit_neg;
   logic [NW:0]     pow;
   logic [NW+1:0]   corr;
   logic            in_range;
   logic [NW:0]     awe;
   logic [RW+1:0]   p_dbl;
   logic [RW:0]     p_next;

   // Constant-divisor modulo of the latched codeword
   assign residue = RW'(cw_q % NW'(A));

   // Candidate match for the current position (+2^i wins over -2^i)
   assign hit_pos = ({1'b0, r_q} == p_q);
   assign hit_neg = ({1'b0, r_q} == (A_W - p_q));

   // Correction evaluated NW+2 bits wide so under/overflow shows in the top bits
   assign pow      = (NW+1)'(1) << i_q;
   assign corr     = hit_pos ? ({2'b00, cw_q} - {1'b0, pow})
                             : ({2'b00, cw_q} + {1'b0, pow});
   assign in_range = (corr[NW+1:NW] == 2'b00);
   assign awe      = hit_pos ? pow : ((NW+1)'(0) - pow);

   // Next power of two modulo A, by conditional subtraction
   assign p_dbl  = {p_q, 1'b0};
   assign p_next = (p_dbl >= A_W2) ? (RW+1)'(p_dbl - A_W2) : p_dbl[RW:0];

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = ovalid_q;
   assign out_cw     = ocw_q;
   assign out_awe    = oawe_q;
   assign out_pos    = opos_q;
   assign out_status = ost_q;

   always_comb begin
      state_d  = state_q;
      cw_d     = cw_q;
      r_d      = r_q;
      i_d      = i_q;
      p_d      = p_q;
      ocw_d    = ocw_q;
      oawe_d   = oawe_q;
      opos_d   = opos_q;
      ost_d    = ost_q;
      ovalid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               cw_d    = in_cw;
               state_d = S_CALC;
            end
         end

         S_CALC: begin
            r_d = residue;
            if (residue == '0) begin
               ocw_d   = cw_q;
               oawe_d  = '0;
               opos_d  = '0;
               ost_d   = ST_CLEAN;
               state_d = S_DONE;
            end else begin
               i_d     = '0;
               p_d     = (RW+1)'(1);
               state_d = S_SEARCH;
            end
         end

         S_SEARCH: begin
            if (hit_pos || hit_neg) begin
               if (in_range) begin
                  ocw_d  = corr[NW-1:0];
                  oawe_d = awe;
                  opos_d = i_q;
                  ost_d  = ST_CORR;
               end else begin
                  ocw_d  = cw_q;
                  oawe_d = '0;
                  opos_d = '0;
                  ost_d  = ST_UNCORR;
               end
               state_d = S_DONE;
            end else if (i_q == I_LAST) begin
               ocw_d   = cw_q;
               oawe_d  = '0;
               opos_d  = '0;
               ost_d   = ST_UNCORR;
               state_d = S_DONE;
            end else begin
               i_d = i_q + PW'(1);
               p_d = p_next;
            end
         end

         S_DONE: begin
            // Result registers settle on entry to DONE; out_valid follows one
            // cycle later and stays up for at least one cycle even if the
            // consumer is already ready.
            if (ovalid_q && out_ready) begin
               state_d = S_IDLE;
            end else begin
               ovalid_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cw_q     <= '0;
         r_q      <= '0;
         i_q      <= '0;
         p_q      <= '0;
         ocw_q    <= '0;
         oawe_q   <= '0;
         opos_q   <= '0;
         ost_q    <= ST_CLEAN;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cw_q     <= cw_d;
         r_q      <= r_d;
         i_q      <= i_d;
         p_q      <= p_d;
         ocw_q    <= ocw_d;
         oawe_q   <= oawe_d;
         opos_q   <= opos_d;
         ost_q    <= ost_d;
         ovalid_q <= ovalid_d;
      end
   end

endmodule

// File: tb/tb_an_sec_search_decoder.sv
// -----------------------------------------------------------------------------
// tb_an_sec_search_decoder
// Scoreboard bench for an_sec_search_decoder: a default instance (A=83, NW=41)
// and a narrow instance (NW=20). Expected results come from a behavioural model
// and are queued at the accepting edge, then compared at the output handshake.
// -----------------------------------------------------------------------------
module tb_an_sec_search_decoder;

   localparam int A   = 83;
   localparam int RW  = 7;
   localparam int NW  = 41;
   localparam int NWS = 20;

   typedef struct {
      longint cw;
      longint awe;
      int     pos;
      int     st;
      int     vedge;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // default-size instance
   logic           v0, rdy0, ov0, ordy0;
   logic [NW-1:0]  cw0, ocw0;
   logic [NW:0]    oawe0;
   logic [5:0]     opos0;
   logic [1:0]     ost0;

   // narrow instance
   logic           v1, rdy1, ov1, ordy1;
   logic [NWS-1:0] cw1, ocw1;
   logic [NWS:0]   oawe1;
   logic [4:0]     opos1;
   logic [1:0]     ost1;

   an_sec_search_decoder #(.A(A), .RW(RW), .NW(NW)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v0), .in_ready(rdy0), .in_cw(cw0),
      .out_valid(ov0), .out_ready(ordy0), .out_cw(ocw0),
      .out_awe(oawe0), .out_pos(opos0), .out_status(ost0)
   );

   an_sec_search_decoder #(.A(A), .RW(RW), .NW(NWS)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v1), .in_ready(rdy1), .in_cw(cw1),
      .out_valid(ov1), .out_ready(ordy1), .out_cw(ocw1),
      .out_awe(oawe1), .out_pos(opos1), .out_status(ost1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Behavioural decode: direct modulo on each power of two, first match wins.
   // vedge holds latency (edges after the accepting edge) until queued.
   function automatic exp_t model(input longint cw, input int nw);
      exp_t   e;
      longint r, p, awe, corr;
      e.cw = cw; e.awe = 0; e.pos = 0; e.st = 0; e.vedge = 2;
      r = cw % A;
      if (r == 0) return e;
      e.st    = 2;
      e.vedge = 2 + nw;
      for (int i = 0; i < nw; i++) begin
         p   = (longint'(1) << i) % A;
         awe = 0;
         if (r == p)          awe = longint'(1) << i;
         else if (r == A - p) awe = -(longint'(1) << i);
         if (awe != 0) begin
            corr    = cw - awe;
            e.vedge = 3 + i;
            if (corr >= 0 && corr < (longint'(1) << nw)) begin
               e.cw = corr; e.awe = awe; e.pos = i; e.st = 1;
            end
            return e;
         end
      end
      return e;
   endfunction

   exp_t q0[$];
   exp_t q1[$];
   bit   seen0 = 1'b0;
   bit   seen1 = 1'b0;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && ov0 === 1'b1) begin
         if (q0.size() == 0) begin
            check("unexpected_valid0", longint'(ov0), 0);
         end else begin
            if (!seen0) begin
               check("latency0", cyc, q0[0].vedge);
               seen0 = 1'b1;
            end
            if (ordy0) begin
               check("cw0",     longint'(ocw0),           q0[0].cw);
               check("awe0",    longint'($signed(oawe0)), q0[0].awe);
               check("pos0",    longint'(opos0),          q0[0].pos);
               check("status0", longint'(ost0),           q0[0].st);
               void'(q0.pop_front());
               seen0 = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && ov1 === 1'b1) begin
         if (q1.size() == 0) begin
            check("unexpected_valid1", longint'(ov1), 0);
         end else begin
            if (!seen1) begin
               check("latency1", cyc, q1[0].vedge);
               seen1 = 1'b1;
            end
            if (ordy1) begin
               check("cw1",     longint'(ocw1),           q1[0].cw);
               check("awe1",    longint'($signed(oawe1)), q1[0].awe);
               check("pos1",    longint'(opos1),          q1[0].pos);
               check("status1", longint'(ost1),           q1[0].st);
               void'(q1.pop_front());
               seen1 = 1'b0;
            end
         end
      end
   end

   // Drivers are entered just after a rising edge; acceptance is decided at the
   // falling edge, where in_ready is stable for the coming rising edge.
   task automatic send0(input longint cw, output int acc);
      exp_t e;
      v0  = 1'b1;
      cw0 = cw[NW-1:0];
      acc = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (rdy0) begin
            acc = cyc + 1;
            e = model(cw, NW);
            e.vedge += acc;
            q0.push_back(e);
            break;
         end
         @(posedge clk); #1;
      end
      if (acc < 0) check("accept_timeout0", longint'(rdy0), 1);
      @(posedge clk); #1;
      v0 = 1'b0;
   endtask

   task automatic send1(input longint cw, output int acc);
      exp_t e;
      v1  = 1'b1;
      cw1 = cw[NWS-1:0];
      acc = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (rdy1) begin
            acc = cyc + 1;
            e = model(cw, NWS);
            e.vedge += acc;
            q1.push_back(e);
            break;
         end
         @(posedge clk); #1;
      end
      if (acc < 0) check("accept_timeout1", longint'(rdy1), 1);
      @(posedge clk); #1;
      v1 = 1'b0;
   endtask

   task automatic drain0();
      for (int k = 0; k < 300; k++) begin
         if (q0.size() == 0) break;
         @(posedge clk); #1;
      end
      check("drain0", q0.size(), 0);
   endtask

   task automatic drain1();
      for (int k = 0; k < 300; k++) begin
         if (q1.size() == 0) break;
         @(posedge clk); #1;
      end
      check("drain1", q1.size(), 0);
   endtask

   initial begin
      int      acc, h;
      longint  cw, base;
      longint  fixed_cw[5];

      rst_n = 1'b0;
      v0 = 1'b0; cw0 = '0; ordy0 = 1'b1;
      v1 = 1'b0; cw1 = '0; ordy1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      check("rst_in_ready",  longint'(rdy0),  1);
      check("rst_out_valid", longint'(ov0),   0);
      check("rst_out_cw",    longint'(ocw0),  0);
      check("rst_out_awe",   longint'(oawe0), 0);
      check("rst_out_pos",   longint'(opos0), 0);
      check("rst_out_st",    longint'(ost0),  0);

      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed cases
      send0(415, acc); drain0();
      send0(543, acc); drain0();
      send0(414, acc); drain0();
      send1(418, acc); drain1();

      // boundary codewords: zero, one, all-ones, all-ones minus one, 2^40
      fixed_cw[0] = 0;
      fixed_cw[1] = 1;
      fixed_cw[2] = (longint'(1) << NW) - 1;
      fixed_cw[3] = (longint'(1) << NW) - 2;
      fixed_cw[4] = longint'(1) << (NW - 1);
      foreach (fixed_cw[j]) begin
         send0(fixed_cw[j], acc);
         drain0();
      end

      // out_ready held low in DONE while the input side is disturbed
      ordy0 = 1'b0;
      send0(543, acc);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (ov0) break;
      end
      repeat (5) begin
         @(posedge clk); #1;
         v0  = ~v0;
         cw0 = NW'($urandom);
         @(negedge clk);
         check("hold_valid",  longint'(ov0),  1);
         check("hold_ready",  longint'(rdy0), 0);
         check("hold_cw",     longint'(ocw0), 415);
         check("hold_awe",    longint'($signed(oawe0)), 128);
         check("hold_status", longint'(ost0), 1);
      end
      @(posedge clk); #1;
      ordy0 = 1'b1;
      h = cyc;
      send0(83 * 7, acc);
      check("accept_after_ready", acc, h + 2);
      drain0();

      // reset while searching position 10
      send0(415 + (longint'(1) << 30), acc);
      while (cyc < acc + 11) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      q0.delete();
      seen0 = 1'b0;
      q1.delete();
      seen1 = 1'b0;
      check("abort_in_ready",  longint'(rdy0),  1);
      check("abort_out_valid", longint'(ov0),   0);
      check("abort_out_cw",    longint'(ocw0),  0);
      check("abort_out_awe",   longint'(oawe0), 0);
      check("abort_out_pos",   longint'(opos0), 0);
      check("abort_out_st",    longint'(ost0),  0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_no_valid", longint'(ov0), 0);
      @(posedge clk); #1;
      send0(415, acc); drain0();

      // random codewords with at most one injected +/-2^i error
      for (int n = 0; n < 12; n++) begin
         base = longint'(A) * longint'($urandom_range(0, 30000000));
         cw   = base;
         case ($urandom_range(0, 2))
            1: cw = base + (longint'(1) << $urandom_range(0, NW - 1));
            2: cw = base - (longint'(1) << $urandom_range(0, NW - 1));
            default: cw = base;
         endcase
         if (cw < 0 || cw >= (longint'(1) << NW)) cw = base;
         ordy0 = 1'($urandom_range(0, 1));
         send0(cw, acc);
         if (!ordy0) begin
            repeat ($urandom_range(1, 50)) @(posedge clk);
            #1;
            ordy0 = 1'b1;
         end
         drain0();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
